imm_issue_ctrl: RTL and testbench

IMM_ISSUE_CTRL -- requirements
Module: imm_issue_ctrl

---
 rtl/imm_issue_ctrl_pkg.sv | 53 +++++
 rtl/imm_issue_ctrl_if.sv | 24 ++
 rtl/imm_issue_ctrl_sign_ext.sv | 27 ++
 rtl/imm_issue_ctrl.sv | 63 ++++++
 tb/tb_imm_issue_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/imm_issue_ctrl_pkg.sv
// Shared opcode constants, immediate class encodings and opcode decode for the
// immediate issue path and the main control unit.
package imm_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        IMM_B  = 2'b00,
        IMM_I  = 2'b01,
        IMM_D  = 2'b10,
        IMM_CB = 2'b11
    } imm_class_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic       illegal;
        imm_class_e cls;
    } decode_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;

    // op is instruction bits [31:21]; shorter opcodes compare against its top bits.
    function automatic decode_t decode_opcode(logic [10:0] op);
        decode_t d;
        d.illegal = 1'b0;
        d.cls     = IMM_B;
        if (op == OP_LDUR || op == OP_STUR) begin
            d.cls = IMM_D;
        end else if (op[10:3] == OP_CBZ || op[10:3] == OP_CBNZ) begin
            d.cls = IMM_CB;
        end else if (op[10:5] == OP_B || op[10:5] == OP_BL) begin
            d.cls = IMM_B;
        end else if (op[10:1] == OP_ADDI || op[10:1] == OP_SUBI ||
                     op[10:1] == OP_ANDI || op[10:1] == OP_ORRI) begin
            d.cls = IMM_I;
        end else begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/imm_issue_ctrl_if.sv
// Instruction-in / immediate-out handshake bundle of the immediate issue block.
interface imm_issue_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic [31:0]      InstrIn;
    logic             InValid;
    logic             InReady;
    logic [63:0]      ImmOut;
    logic [1:0]       ImmCtrl;
    logic             Illegal;
    logic             OutValid;
    logic             OutReady;
    logic [CNT_W-1:0] IllegalCount;

    modport master (
        output InstrIn, InValid, OutReady,
        input  InReady, ImmOut, ImmCtrl, Illegal, OutValid, IllegalCount
    );

    modport slave (
        input  InstrIn, InValid, OutReady,
        output InReady, ImmOut, ImmCtrl, Illegal, OutValid, IllegalCount
    );
endinterface

// File: rtl/imm_issue_ctrl_sign_ext.sv
// SignExtender: builds the 64-bit immediate from the low 26 instruction bits
// according to the decoded immediate class.
module SignExtender
    import imm_issue_ctrl_pkg::*;
(
    input  logic [25:0] imm26,
    input  imm_class_e  ctrl,
    output logic [63:0] imm
);

    // Bit 24 is not part of any immediate field.
    logic unused_bit24;
    assign unused_bit24 = imm26[24];

    // Branch form keeps Imm26[22:0] at [24:2]; everything above is sign fill.
    always_comb begin
        imm = '0;
        case (ctrl)
            IMM_B:   imm = {{39{imm26[25]}}, imm26[22:0], 2'b00};
            IMM_I:   imm = {52'd0, imm26[21:10]};
            IMM_D:   imm = {{55{imm26[20]}}, imm26[20:12]};
            IMM_CB:  imm = {{43{imm26[23]}}, imm26[23:5], 2'b00};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_issue_ctrl.sv
// Immediate issue control: decodes the fetched word, extends its immediate and
// holds the result in a one-entry output register with a saturating illegal count.
module imm_issue_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input logic              Clk,
    input logic              Reset,
    imm_issue_ctrl_if.slave  io
);
    import imm_issue_ctrl_pkg::*;

    out_state_e       state;
    logic [63:0]      imm_q;
    imm_class_e       ctrl_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    decode_t          dec;
    logic [63:0]      ext_imm;
    logic             in_ready;
    logic             accept;

    assign dec = decode_opcode(io.InstrIn[31:21]);

    SignExtender u_sign_ext (
        .imm26 (io.InstrIn[25:0]),
        .ctrl  (dec.cls),
        .imm   (ext_imm)
    );

    assign in_ready = (state == OUT_EMPTY) || io.OutReady;
    assign accept   = io.InValid && in_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= OUT_EMPTY;
            imm_q     <= '0;
            ctrl_q    <= IMM_B;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                state     <= OUT_FULL;
                illegal_q <= dec.illegal;
                imm_q     <= dec.illegal ? '0 : ext_imm;
                ctrl_q    <= dec.illegal ? IMM_B : dec.cls;
                if (dec.illegal && cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (state == OUT_FULL && io.OutReady) begin
                state <= OUT_EMPTY;
            end
        end
    end

    assign io.InReady      = in_ready;
    assign io.OutValid     = (state == OUT_FULL);
    assign io.ImmOut       = imm_q;
    assign io.ImmCtrl      = ctrl_q;
    assign io.Illegal      = illegal_q;
    assign io.IllegalCount = cnt_q;

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Self-checking bench for imm_issue_ctrl: directed literal cases plus randomized
// traffic compared every cycle against a behavioural model.
module tb_imm_issue_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    imm_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

    imm_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .io    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: immediate value computed arithmetically from the field rules.
    task automatic ref_decode(input logic [31:0] instr, output logic ill,
                              output logic [1:0] cls, output logic [63:0] imm);
        logic [25:0] f;
        longint v;
        f = instr[25:0];
        ill = 1'b0;
        cls = 2'b00;
        v = 0;
        if (instr[31:21] == 11'h7C2 || instr[31:21] == 11'h7C0) begin
            cls = 2'b10;
            v = longint'(f[20:12]);
            if (f[20]) v = v - 512;
        end else if (instr[31:24] == 8'hB4 || instr[31:24] == 8'hB5) begin
            cls = 2'b11;
            v = longint'(f[23:5]) * 4;
            if (f[23]) v = v - (longint'(1) << 21);
        end else if (instr[31:26] == 6'h05 || instr[31:26] == 6'h25) begin
            cls = 2'b00;
            v = longint'(f[22:0]) * 4;
            if (f[25]) v = v - (longint'(1) << 25);
        end else if (instr[31:22] == 10'h244 || instr[31:22] == 10'h344 ||
                     instr[31:22] == 10'h248 || instr[31:22] == 10'h2C8) begin
            cls = 2'b01;
            v = longint'(f[21:10]);
        end else begin
            ill = 1'b1;
        end
        imm = 64'(v);
    endtask

    logic        model_on = 1'b0;
    logic        m_valid;
    logic [63:0] m_imm;
    logic [1:0]  m_ctrl;
    logic        m_ill;
    int unsigned m_cnt;

    always @(posedge clk) begin
        logic d_ill;
        logic [1:0] d_cls;
        logic [63:0] d_imm;
        if (rst) begin
            m_valid = 1'b0; m_imm = '0; m_ctrl = 2'b00; m_ill = 1'b0; m_cnt = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            if (bus.InValid && (!m_valid || bus.OutReady)) begin
                ref_decode(bus.InstrIn, d_ill, d_cls, d_imm);
                m_valid = 1'b1;
                m_ill   = d_ill;
                m_ctrl  = d_ill ? 2'b00 : d_cls;
                m_imm   = d_ill ? 64'd0 : d_imm;
                if (d_ill && m_cnt < CNT_MAX) m_cnt++;
            end else if (m_valid && bus.OutReady) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("in_ready",  64'(bus.InReady),      64'(!m_valid || bus.OutReady));
            chk("out_valid", 64'(bus.OutValid),     64'(m_valid));
            chk("imm_out",   bus.ImmOut,            m_imm);
            chk("imm_ctrl",  64'(bus.ImmCtrl),      64'(m_ctrl));
            chk("illegal",   64'(bus.Illegal),      64'(m_ill));
            chk("ill_count", 64'(bus.IllegalCount), 64'(m_cnt));
        end
    end

    task automatic drive(input logic r, input logic [31:0] instr, input logic v, input logic ordy);
        rst = r;
        bus.InstrIn = instr;
        bus.InValid = v;
        bus.OutReady = ordy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 10))
            0:       return {11'h7C2, r[20:0]};
            1:       return {11'h7C0, r[20:0]};
            2:       return {8'hB4, r[23:0]};
            3:       return {8'hB5, r[23:0]};
            4:       return {6'h05, r[25:0]};
            5:       return {6'h25, r[25:0]};
            6:       return {10'h244, r[21:0]};
            7:       return {10'h344, r[21:0]};
            8:       return {10'h248, r[21:0]};
            9:       return {10'h2C8, r[21:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.InstrIn = '0;
        bus.InValid = 1'b0;
        bus.OutReady = 1'b0;

        drive(1, 32'h0, 0, 0);
        drive(1, 32'h0, 0, 0);
        chk("rst_valid", 64'(bus.OutValid), 64'd0);
        chk("rst_imm",   bus.ImmOut, 64'd0);
        chk("rst_ctrl",  64'(bus.ImmCtrl), 64'd0);
        chk("rst_ill",   64'(bus.Illegal), 64'd0);
        chk("rst_cnt",   64'(bus.IllegalCount), 64'd0);
        chk("rst_rdy",   64'(bus.InReady), 64'd1);

        drive(0, 32'h913FFC00, 1, 1);
        chk("addi_valid", 64'(bus.OutValid), 64'd1);
        chk("addi_ctrl",  64'(bus.ImmCtrl), 64'd1);
        chk("addi_imm",   bus.ImmOut, 64'h0000000000000FFF);
        chk("addi_ill",   64'(bus.Illegal), 64'd0);

        drive(0, 32'h17FFFFFF, 1, 1);
        chk("b_valid", 64'(bus.OutValid), 64'd1);
        chk("b_ctrl",  64'(bus.ImmCtrl), 64'd0);
        chk("b_imm",   bus.ImmOut, 64'hFFFFFFFFFFFFFFFC);
        drive(0, 32'hB4FFFFE0, 1, 1);
        chk("cbz_valid", 64'(bus.OutValid), 64'd1);
        chk("cbz_ctrl",  64'(bus.ImmCtrl), 64'd3);
        chk("cbz_imm",   bus.ImmOut, 64'hFFFFFFFFFFFFFFFC);

        drive(0, 32'hF8500000, 1, 1);
        chk("ldur_imm",  bus.ImmOut, 64'hFFFFFFFFFFFFFF00);
        chk("ldur_ctrl", 64'(bus.ImmCtrl), 64'd2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h913FFC00, 1, 0);
            chk("stall_rdy",   64'(bus.InReady), 64'd0);
            chk("stall_valid", 64'(bus.OutValid), 64'd1);
            chk("stall_imm",   bus.ImmOut, 64'hFFFFFFFFFFFFFF00);
            chk("stall_ctrl",  64'(bus.ImmCtrl), 64'd2);
        end
        drive(0, 32'h0, 0, 1);
        chk("release_valid", 64'(bus.OutValid), 64'd0);
        chk("release_hold",  bus.ImmOut, 64'hFFFFFFFFFFFFFF00);

        for (int i = 0; i < 257; i++) begin
            drive(0, 32'h00000000, 1, 1);
            chk("ill_flag",  64'(bus.Illegal), 64'd1);
            chk("ill_imm",   bus.ImmOut, 64'd0);
            chk("ill_count", 64'(bus.IllegalCount), 64'((i + 1 > 255) ? 255 : i + 1));
        end
        chk("ill_sat", 64'(bus.IllegalCount), 64'd255);

        drive(0, 32'h913FFC00, 1, 0);
        chk("pre_rst_valid", 64'(bus.OutValid), 64'd1);
        drive(1, 32'h913FFC00, 1, 0);
        chk("rst_full_valid", 64'(bus.OutValid), 64'd0);
        chk("rst_full_cnt",   64'(bus.IllegalCount), 64'd0);
        chk("rst_full_rdy",   64'(bus.InReady), 64'd1);
        drive(0, 32'h0, 0, 1);
        chk("rst_discard", 64'(bus.OutValid), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), rand_instr(),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
        end
        drive(0, 32'h0, 0, 1);
        drive(0, 32'h0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
